// File: rtl/a_pkg.sv
// Shared types and helpers for the a_frame_packer family.
// The index-width helper keeps one-entry dimensions at one bit wide.
package a_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } a_pack_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/a_frame_ctr.sv
// Two-dimensional slot counter for the frame packer.
// It walks beat index a within lane v and counts the beats that have been stored.
module a_frame_ctr
    import a_pkg::*;
#(
    parameter  int AUM = 80,
    parameter  int VUM = 1,
    localparam int AW  = idx_w(AUM),
    localparam int VW  = idx_w(VUM),
    localparam int CW  = $clog2(AUM*VUM+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] a_idx,
    output logic [VW-1:0] v_idx,
    output logic [CW-1:0] out_beats,
    output logic          last_slot
);

    localparam logic [AW-1:0] A_LAST = AW'(AUM-1);
    localparam logic [VW-1:0] V_LAST = VW'(VUM-1);
    localparam logic [CW-1:0] B_MAX  = CW'(AUM*VUM);

    assign last_slot = (a_idx == A_LAST) && (v_idx == V_LAST);

    // On the final slot the indices park; the packer leaves FILL at that point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_idx     <= '0;
            v_idx     <= '0;
            out_beats <= '0;
        end else if (clr) begin
            a_idx     <= '0;
            v_idx     <= '0;
            out_beats <= '0;
        end else if (inc) begin
            if (out_beats != B_MAX) begin
                out_beats <= out_beats + 1'b1;
            end
            if (!last_slot) begin
                if (a_idx == A_LAST) begin
                    a_idx <= '0;
                    v_idx <= v_idx + 1'b1;
                end else begin
                    a_idx <= a_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/a_frame_packer.sv
// Packs a valid/ready beat stream into a VUM x AUM frame held stable until accepted.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; holding valid high without ready is allowed.
module a_frame_packer
    import a_pkg::*;
#(
    parameter  int AUM = 80,
    parameter  int BUM = 70,
    parameter  int VUM = 1,
    localparam int CW  = $clog2(AUM*VUM+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BUM-1:0]           in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AUM-1:0][BUM-1:0]  my_data_abv [VUM],
    output logic [AUM-1:0]           my_data_av  [VUM],
    output logic                     my_data_z,
    output logic [CW-1:0]            out_beats,
    output a_pack_state_e            dbg_state
);

    localparam int AW = idx_w(AUM);
    localparam int VW = idx_w(VUM);

    a_pack_state_e state_q, state_d;
    logic          ready_c;
    logic          inc;
    logic          clr;
    logic          drop;
    logic [AW-1:0] a_idx;
    logic [VW-1:0] v_idx;
    logic          last_slot;

    a_frame_ctr #(
        .AUM(AUM),
        .VUM(VUM)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .clr      (clr),
        .a_idx    (a_idx),
        .v_idx    (v_idx),
        .out_beats(out_beats),
        .last_slot(last_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_c   = 1'b0;
        out_valid = 1'b0;
        inc       = 1'b0;
        clr       = 1'b0;
        drop      = 1'b0;
        case (state_q)
            FILL: begin
                ready_c = 1'b1;
                if (in_valid && !rst) begin
                    inc = 1'b1;
                    if (in_last) begin
                        state_d = HOLD;
                    end else if (last_slot) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                ready_c = 1'b1;
                if (in_valid && !rst) begin
                    drop = 1'b1;
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clr     = 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Reset forces the state to FILL, so ready must also be masked by rst itself.
    assign in_ready  = ready_c && !rst;
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VUM; v++) begin
                my_data_abv[v] <= '0;
                my_data_av[v]  <= '0;
            end
            my_data_z <= 1'b0;
        end else if (clr) begin
            for (int v = 0; v < VUM; v++) begin
                my_data_abv[v] <= '0;
                my_data_av[v]  <= '0;
            end
            my_data_z <= 1'b0;
        end else begin
            if (inc) begin
                for (int v = 0; v < VUM; v++) begin
                    if (VW'(v) == v_idx) begin
                        my_data_abv[v][a_idx] <= in_data;
                        my_data_av[v][a_idx]  <= 1'b1;
                    end
                end
            end
            if (drop) begin
                my_data_z <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_a_frame_packer.sv
// Directed bench for a_frame_packer: a small 4x8x2 instance and a default-parameter instance.
module tb_a_frame_packer;
    import a_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // small instance: AUM=4, BUM=8, VUM=2
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [7:0]           in_data  = '0;
    logic                 in_last  = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [3:0][7:0]      abv [2];
    logic [3:0]           av  [2];
    logic                 z;
    logic [3:0]           beats;
    a_pack_state_e        st;

    // default instance: AUM=80, BUM=70, VUM=1
    logic                 b_in_valid = 1'b0;
    logic                 b_in_ready;
    logic [69:0]          b_in_data  = '0;
    logic                 b_in_last  = 1'b0;
    logic                 b_out_valid;
    logic                 b_out_ready = 1'b0;
    logic [79:0][69:0]    b_abv [1];
    logic [79:0]          b_av  [1];
    logic                 b_z;
    logic [6:0]           b_beats;
    a_pack_state_e        b_st;

    int n_tests = 0;
    int n_fail  = 0;
    logic [69:0] exp_q [$];

    a_frame_packer #(.AUM(4), .BUM(8), .VUM(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .my_data_abv(abv), .my_data_av(av),
        .my_data_z(z), .out_beats(beats), .dbg_state(st)
    );

    a_frame_packer u_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .my_data_abv(b_abv), .my_data_av(b_av),
        .my_data_z(b_z), .out_beats(b_beats), .dbg_state(b_st)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic accept_frame();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++; if (beats !== 4'd0) begin n_fail++; $display("FAIL reset_beats got %0d exp 0", beats); end
        n_tests++; if ({av[1], av[0]} !== 8'h00 || z !== 1'b0) begin n_fail++; $display("FAIL reset_mask_z got av=%h z=%b exp 00/0", {av[1], av[0]}, z); end
        n_tests++; if (st !== FILL) begin n_fail++; $display("FAIL reset_state got %0d exp FILL", st); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_exact_frame();
        for (int i = 0; i < 8; i++) send_beat(8'h10 + 8'(i), i == 7);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL exact_valid got %b exp 1", out_valid); end
        n_tests++; if (abv[0] !== 32'h13121110) begin n_fail++; $display("FAIL exact_abv0 got %h exp 13121110", abv[0]); end
        n_tests++; if (abv[1] !== 32'h17161514) begin n_fail++; $display("FAIL exact_abv1 got %h exp 17161514", abv[1]); end
        n_tests++; if (av[0] !== 4'hF || av[1] !== 4'hF) begin n_fail++; $display("FAIL exact_av got %h/%h exp F/F", av[1], av[0]); end
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL exact_z got %b exp 0", z); end
        n_tests++; if (beats !== 4'd8) begin n_fail++; $display("FAIL exact_beats got %0d exp 8", beats); end
        n_tests++; if (in_ready !== 1'b0 || st !== HOLD) begin n_fail++; $display("FAIL exact_hold got ready=%b st=%0d exp 0/HOLD", in_ready, st); end
        accept_frame();
        n_tests++; if (out_valid !== 1'b0 || av[0] !== 4'h0 || beats !== 4'd0) begin n_fail++; $display("FAIL exact_clear got v=%b av=%h beats=%0d exp 0/0/0", out_valid, av[0], beats); end
    endtask

    task automatic test_short_frame();
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL short_early_valid got %b exp 0", out_valid); end
        send_beat(8'hA3, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid got %b exp 1", out_valid); end
        n_tests++; if (av[0] !== 4'b0111 || av[1] !== 4'b0000) begin n_fail++; $display("FAIL short_av got %b/%b exp 0000/0111", av[1], av[0]); end
        n_tests++; if (abv[0] !== 32'h00A3A2A1 || abv[1] !== 32'h0) begin n_fail++; $display("FAIL short_abv got %h/%h exp 00000000/00A3A2A1", abv[1], abv[0]); end
        n_tests++; if (beats !== 4'd3) begin n_fail++; $display("FAIL short_beats got %0d exp 3", beats); end
        accept_frame();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) send_beat(8'h20 + 8'(i), 1'b0);
        n_tests++; if (st !== DRAIN || z !== 1'b0) begin n_fail++; $display("FAIL ovf_enter got st=%0d z=%b exp DRAIN/0", st, z); end
        send_beat(8'h28, 1'b0);
        n_tests++; if (st !== DRAIN || z !== 1'b1) begin n_fail++; $display("FAIL ovf_first_drop got st=%0d z=%b exp DRAIN/1", st, z); end
        send_beat(8'h29, 1'b0);
        n_tests++; if (st !== DRAIN || out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain got st=%0d v=%b exp DRAIN/0", st, out_valid); end
        send_beat(8'h2A, 1'b1);
        n_tests++; if (out_valid !== 1'b1 || z !== 1'b1) begin n_fail++; $display("FAIL ovf_hold got v=%b z=%b exp 1/1", out_valid, z); end
        n_tests++; if (beats !== 4'd8) begin n_fail++; $display("FAIL ovf_beats got %0d exp 8", beats); end
        n_tests++; if (abv[0] !== 32'h23222120 || abv[1] !== 32'h27262524) begin n_fail++; $display("FAIL ovf_abv got %h/%h exp 27262524/23222120", abv[1], abv[0]); end
        accept_frame();
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL ovf_z_clear got %b exp 0", z); end
    endtask

    task automatic test_backpressure();
        send_beat(8'h55, 1'b0);
        send_beat(8'h66, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || abv[0] !== 32'h00006655 || av[0] !== 4'b0011 || beats !== 4'd2) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got ready=%b v=%b abv0=%h av0=%b beats=%0d exp 0/1/00006655/0011/2", c, in_ready, out_valid, abv[0], av[0], beats);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b ready=%b exp 0/1", out_valid, in_ready); end
        n_tests++; if (abv[0] !== 32'h0 || av[0] !== 4'h0 || beats !== 4'd0 || z !== 1'b0) begin n_fail++; $display("FAIL bp_cleared got abv0=%h av0=%h beats=%0d z=%b exp 0", abv[0], av[0], beats, z); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) send_beat(8'h30 + 8'(i), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        n_tests++; if (beats !== 4'd0 || av[0] !== 4'h0 || av[1] !== 4'h0 || abv[0] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_clear got beats=%0d av=%h/%h abv0=%h exp 0", beats, av[1], av[0], abv[0]); end
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || st !== FILL) begin n_fail++; $display("FAIL rst_mid_ctl got ready=%b v=%b st=%0d exp 0/0/FILL", in_ready, out_valid, st); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b1);
        n_tests++; if (out_valid !== 1'b1 || beats !== 4'd2 || abv[0] !== 32'h00000201) begin n_fail++; $display("FAIL rst_mid_after got v=%b beats=%0d abv0=%h exp 1/2/00000201", out_valid, beats, abv[0]); end
        accept_frame();
    endtask

    task automatic test_defaults_random();
        logic [69:0] d;
        exp_q.delete();
        for (int i = 0; i < 80; i++) begin
            d = {$urandom_range(63, 0), $urandom, $urandom};
            exp_q.push_back(d);
            b_in_valid = 1'b1;
            b_in_data  = d;
            b_in_last  = (i == 79);
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        n_tests++; if (b_out_valid !== 1'b1 || b_beats !== 7'd80 || b_z !== 1'b0) begin n_fail++; $display("FAIL big_status got v=%b beats=%0d z=%b exp 1/80/0", b_out_valid, b_beats, b_z); end
        n_tests++; if (b_av[0] !== {80{1'b1}}) begin n_fail++; $display("FAIL big_av got %h exp all ones", b_av[0]); end
        for (int i = 0; i < 80; i++) begin
            n_tests++;
            if (b_abv[0][i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL big_abv_%0d got %h exp %h", i, b_abv[0][i], exp_q[i]);
            end
        end
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        n_tests++; if (b_out_valid !== 1'b0 || b_beats !== 7'd0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL big_release got v=%b beats=%0d ready=%b exp 0/0/1", b_out_valid, b_beats, b_in_ready); end
    endtask

    initial begin
        test_reset();
        test_exact_frame();
        test_short_frame();
        test_overflow();
        test_backpressure();
        test_reset_mid_frame();
        test_defaults_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
